// File: rtl/sha1_round_ctrl_if.sv
`default_nettype none
// ============================================================================
// sha1_round_ctrl_if : block handshake and datapath control bundle.  rev 1.0
// ============================================================================
interface sha1_round_ctrl_if;
   logic       blk_valid;
   logic       blk_first;
   logic       blk_last;
   logic       blk_ready;
   logic       abort;
   logic       dp_init_h;
   logic       dp_load_w;
   logic       dp_round_en;
   logic [6:0] dp_round;
   logic [1:0] dp_fsel;
   logic       dp_update_h;
   logic       digest_valid;
   logic       digest_ack;
   logic       busy;
   logic       err;

   modport master (
      output blk_valid, blk_first, blk_last, abort, digest_ack,
      input  blk_ready, dp_init_h, dp_load_w, dp_round_en, dp_round, dp_fsel,
             dp_update_h, digest_valid, busy, err
   );

   modport slave (
      input  blk_valid, blk_first, blk_last, abort, digest_ack,
      output blk_ready, dp_init_h, dp_load_w, dp_round_en, dp_round, dp_fsel,
             dp_update_h, digest_valid, busy, err
   );
endinterface
`default_nettype wire

// File: rtl/sha1_round_ctrl.sv
`default_nettype none
// ============================================================================
// sha1_round_ctrl : SHA-1 block/round sequencer driving an external datapath.
// rev 1.0
// ============================================================================
module sha1_round_ctrl #(
   parameter int ROUNDS = 80
) (
   input  wire logic         clk,
   input  wire logic         rst,
   sha1_round_ctrl_if.slave  bus
);

   localparam logic [6:0] c_last_t = 7'(ROUNDS - 1);
   localparam logic [6:0] c_q1     = 7'(ROUNDS / 4);
   localparam logic [6:0] c_q2     = 7'(ROUNDS / 2);
   localparam logic [6:0] c_q3     = 7'((3 * ROUNDS) / 4);

   if ((ROUNDS % 4) != 0 || ROUNDS < 4 || ROUNDS > 128) begin : g_bad_rounds
      $error("sha1_round_ctrl: ROUNDS must be a multiple of 4 in 4..128");
   end

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_ROUND  = 3'd2,
      ST_UPDATE = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   state_e     state_q, state_d;
   logic [6:0] t_q, t_d;
   logic       first_q, first_d;
   logic       last_q, last_d;
   logic       msg_active_q, msg_d;
   logic       err_d;
   logic [1:0] fsel_d;

   logic       dp_init_h_q, dp_load_w_q, dp_round_en_q, dp_update_h_q;
   logic [6:0] dp_round_q;
   logic [1:0] dp_fsel_q;
   logic       digest_valid_q, busy_q, err_q;

   logic       w_blk_ready;
   logic       w_hs;

   // Ready is the only output that looks at inputs; it is forced low in reset.
   assign w_blk_ready = (state_q == ST_IDLE) & ~bus.abort & ~rst;
   assign w_hs        = bus.blk_valid & w_blk_ready;

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      first_d = first_q;
      last_d  = last_q;
      msg_d   = msg_active_q;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.abort) begin
               msg_d = 1'b0;
            end else if (w_hs) begin
               if (!bus.blk_first && !msg_active_q) begin
                  err_d = 1'b1;
               end else begin
                  state_d = ST_LOAD;
                  first_d = bus.blk_first;
                  last_d  = bus.blk_last;
                  if (bus.blk_first) msg_d = 1'b1;
               end
            end
         end
         ST_LOAD: begin
            state_d = ST_ROUND;
            t_d     = 7'd0;
         end
         ST_ROUND: begin
            if (t_q == c_last_t) begin
               state_d = ST_UPDATE;
               t_d     = 7'd0;
            end else begin
               t_d = t_q + 7'd1;
            end
         end
         ST_UPDATE: begin
            if (last_q) begin
               state_d = ST_DONE;
               msg_d   = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DONE: begin
            if (bus.digest_ack) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (bus.abort && state_q != ST_IDLE) begin
         state_d = ST_IDLE;
         t_d     = 7'd0;
         msg_d   = 1'b0;
      end
   end

   // Round-function group, by threshold compare rather than a divider.
   always_comb begin
      fsel_d = 2'd0;
      if (t_d >= c_q3)      fsel_d = 2'd3;
      else if (t_d >= c_q2) fsel_d = 2'd2;
      else if (t_d >= c_q1) fsel_d = 2'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         t_q            <= 7'd0;
         first_q        <= 1'b0;
         last_q         <= 1'b0;
         msg_active_q   <= 1'b0;
         dp_init_h_q    <= 1'b0;
         dp_load_w_q    <= 1'b0;
         dp_round_en_q  <= 1'b0;
         dp_round_q     <= 7'd0;
         dp_fsel_q      <= 2'd0;
         dp_update_h_q  <= 1'b0;
         digest_valid_q <= 1'b0;
         busy_q         <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         t_q            <= t_d;
         first_q        <= first_d;
         last_q         <= last_d;
         msg_active_q   <= msg_d;
         dp_init_h_q    <= (state_d == ST_LOAD) & first_d;
         dp_load_w_q    <= (state_d == ST_LOAD);
         dp_round_en_q  <= (state_d == ST_ROUND);
         dp_round_q     <= (state_d == ST_ROUND) ? t_d : 7'd0;
         dp_fsel_q      <= (state_d == ST_ROUND) ? fsel_d : 2'd0;
         dp_update_h_q  <= (state_d == ST_UPDATE);
         digest_valid_q <= (state_d == ST_DONE);
         busy_q         <= (state_d != ST_IDLE);
         err_q          <= err_d;
      end
   end

   assign bus.blk_ready    = w_blk_ready;
   assign bus.dp_init_h    = dp_init_h_q;
   assign bus.dp_load_w    = dp_load_w_q;
   assign bus.dp_round_en  = dp_round_en_q;
   assign bus.dp_round     = dp_round_q;
   assign bus.dp_fsel      = dp_fsel_q;
   assign bus.dp_update_h  = dp_update_h_q;
   assign bus.digest_valid = digest_valid_q;
   assign bus.busy         = busy_q;
   assign bus.err          = err_q;

endmodule
`default_nettype wire
